// File: rtl/rv32i_decode_exec.sv
// rtl/rv32i_decode_exec.sv - RV32I single-cycle decode/execute slice with registered ALU result
module rv32i_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            alu_a_src,
  output logic [1:0]      alu_b_src,
  output logic [3:0]      alu_ctrl,
  output logic [2:0]      branch,
  output logic            mem_to_reg,
  output logic [2:0]      mem_op,
  output logic            mem_wr,
  output logic            reg_wr,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            less_flag,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q,
  output logic            less_q
);

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  imm_fmt_e        imm_fmt;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            f7b5;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] result_d;
  logic            zero_d;
  logic            less_d;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7b5   = instr[30];
  assign mem_op = f3;

  always_comb begin
    alu_a_src  = 1'b1;
    alu_b_src  = 2'b00;
    alu_ctrl   = 4'b0000;
    branch     = 3'b000;
    mem_to_reg = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    imm_fmt    = IMM_NONE;
    case (opcode)
      7'b0110011: begin
        alu_ctrl = {f7b5, f3};
        reg_wr   = 1'b1;
      end
      7'b0010011: begin
        alu_b_src = 2'b01;
        alu_ctrl  = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
        reg_wr    = 1'b1;
        imm_fmt   = IMM_I;
      end
      7'b0000011: begin
        alu_b_src  = 2'b01;
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        imm_fmt    = IMM_I;
      end
      7'b0100011: begin
        alu_b_src = 2'b01;
        mem_wr    = 1'b1;
        imm_fmt   = IMM_S;
      end
      7'b1100011: begin
        imm_fmt  = IMM_B;
        alu_ctrl = 4'b1000;
        case (f3)
          3'b000: branch = 3'b100;
          3'b001: branch = 3'b101;
          3'b100: branch = 3'b110;
          3'b101: branch = 3'b111;
          3'b110: begin branch = 3'b110; alu_ctrl = 4'b0011; end
          3'b111: begin branch = 3'b111; alu_ctrl = 4'b0011; end
          default: branch = 3'b000;
        endcase
      end
      7'b0110111: begin
        alu_b_src = 2'b01;
        alu_ctrl  = 4'b1111;
        reg_wr    = 1'b1;
        imm_fmt   = IMM_U;
      end
      7'b0010111: begin
        alu_a_src = 1'b0;
        alu_b_src = 2'b01;
        reg_wr    = 1'b1;
        imm_fmt   = IMM_U;
      end
      7'b1101111: begin
        alu_a_src = 1'b0;
        alu_b_src = 2'b10;
        reg_wr    = 1'b1;
        branch    = 3'b001;
        imm_fmt   = IMM_J;
      end
      7'b1100111: begin
        alu_a_src = 1'b0;
        alu_b_src = 2'b10;
        reg_wr    = 1'b1;
        branch    = 3'b010;
        imm_fmt   = IMM_I;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign op_a = alu_a_src ? rs1 : pc;

  always_comb begin
    case (alu_b_src)
      2'b00:   op_b = rs2;
      2'b01:   op_b = imm;
      2'b10:   op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;

  always_comb begin
    case (alu_ctrl)
      4'b0000: result = op_a + op_b;
      4'b1000: result = op_a - op_b;
      4'b0001: result = op_a << op_b[4:0];
      4'b0010: result = {{(XLEN-1){1'b0}}, lt_s};
      4'b0011: result = {{(XLEN-1){1'b0}}, lt_u};
      4'b0100: result = op_a ^ op_b;
      4'b0101: result = op_a >> op_b[4:0];
      4'b1101: result = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'b0110: result = op_a | op_b;
      4'b0111: result = op_a & op_b;
      4'b1111: result = op_b;
      default: result = '0;
    endcase
  end

  assign zero_flag = (result == '0);
  assign less_flag = (alu_ctrl == 4'b0011) ? lt_u : lt_s;

  always_comb begin
    result_d = result;
    zero_d   = zero_flag;
    less_d   = less_flag;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      less_q   <= less_d;
    end
  end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb/tb_rv32i_decode_exec.sv - directed and random checks of rv32i_decode_exec against an ISA-level model
module tb_rv32i_decode_exec;

  logic        clk;
  logic        clr;
  logic [31:0] instr, pc, rs1, rs2;
  logic        alu_a_src;
  logic [1:0]  alu_b_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  branch;
  logic        mem_to_reg;
  logic [2:0]  mem_op;
  logic        mem_wr, reg_wr;
  logic [31:0] imm, result;
  logic        zero_flag, less_flag;
  logic [31:0] result_q;
  logic        zero_q, less_q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        a_src;
    logic [1:0]  b_src;
    logic [3:0]  ctrl;
    logic [2:0]  br;
    logic        m2r;
    logic [2:0]  mop;
    logic        mwr;
    logic        rwr;
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
    logic        lt;
  } exp_t;

  rv32i_decode_exec #(.XLEN(32)) dut (
    .clk(clk), .clr(clr), .instr(instr), .pc(pc), .rs1(rs1), .rs2(rs2),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_ctrl(alu_ctrl),
    .branch(branch), .mem_to_reg(mem_to_reg), .mem_op(mem_op),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .imm(imm), .result(result),
    .zero_flag(zero_flag), .less_flag(less_flag),
    .result_q(result_q), .zero_q(zero_q), .less_q(less_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd1:  return a << sh;
      4'd2:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd13: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd15: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, a, b;
    logic [2:0] f3;
    f3 = in[14:12];
    i_imm = $unsigned($signed(in) >>> 20);
    s_imm = (i_imm & 32'hFFFF_FFE0) | ((in >> 7) & 32'h1F);
    b_imm = (s_imm & ~32'h0000_0801) | (32'(in[7]) << 11);
    u_imm = in & 32'hFFFF_F000;
    j_imm = (i_imm & 32'hFFF0_0000) | (in & 32'h000F_F000) | (32'(in[20]) << 11) | ((in >> 20) & 32'h7FE);
    e = '0;
    e.a_src = 1'b1;
    e.mop = f3;
    case (in[6:0])
      7'h33: begin e.ctrl = {in[30], f3}; e.rwr = 1; end
      7'h13: begin e.b_src = 1; e.imm = i_imm; e.rwr = 1; e.ctrl = {(f3 == 5) & in[30], f3}; end
      7'h03: begin e.b_src = 1; e.imm = i_imm; e.rwr = 1; e.m2r = 1; end
      7'h23: begin e.b_src = 1; e.imm = s_imm; e.mwr = 1; end
      7'h63: begin
        e.imm = b_imm;
        e.ctrl = (f3 >= 6) ? 4'd3 : 4'd8;
        case (f3)
          0: e.br = 3'b100;
          1: e.br = 3'b101;
          4, 6: e.br = 3'b110;
          5, 7: e.br = 3'b111;
          default: e.br = 3'b000;
        endcase
      end
      7'h37: begin e.b_src = 1; e.imm = u_imm; e.ctrl = 4'd15; e.rwr = 1; end
      7'h17: begin e.a_src = 0; e.b_src = 1; e.imm = u_imm; e.rwr = 1; end
      7'h6F: begin e.a_src = 0; e.b_src = 2; e.imm = j_imm; e.rwr = 1; e.br = 3'b001; end
      7'h67: begin e.a_src = 0; e.b_src = 2; e.imm = i_imm; e.rwr = 1; e.br = 3'b010; end
      default: ;
    endcase
    a = e.a_src ? r1 : p;
    b = (e.b_src == 0) ? r2 : (e.b_src == 1) ? e.imm : 32'd4;
    e.res = ref_alu(e.ctrl, a, b);
    e.z = (e.res == 0);
    e.lt = (e.ctrl == 4'd3) ? (a < b) : ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    instr = i; pc = p; rs1 = a; rs2 = b;
    #1;
    e = model(i, p, a, b);
    chk("alu_a_src", 32'(alu_a_src), 32'(e.a_src));
    chk("alu_b_src", 32'(alu_b_src), 32'(e.b_src));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
    chk("branch", 32'(branch), 32'(e.br));
    chk("mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
    chk("mem_op", 32'(mem_op), 32'(e.mop));
    chk("mem_wr", 32'(mem_wr), 32'(e.mwr));
    chk("reg_wr", 32'(reg_wr), 32'(e.rwr));
    chk("imm", imm, e.imm);
    chk("result", result, e.res);
    chk("zero_flag", 32'(zero_flag), 32'(e.z));
    chk("less_flag", 32'(less_flag), 32'(e.lt));
    @(posedge clk);
    #1;
    chk("result_q", result_q, e.res);
    chk("zero_q", 32'(zero_q), 32'(e.z));
    chk("less_q", 32'(less_q), 32'(e.lt));
  endtask

  logic [6:0] opcodes [13] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h67, 7'h7F, 7'h00, 7'h0F, 7'h73};

  initial begin
    logic [31:0] ri;
    clr = 1'b0; instr = 32'h0; pc = 32'h0; rs1 = 32'h0; rs2 = 32'h0;
    @(posedge clk); #1;
    chk("reset_result_q", result_q, 32'h0);
    chk("reset_zero_q", 32'(zero_q), 32'h0);
    chk("reset_less_q", 32'(less_q), 32'h0);
    @(negedge clk);
    clr = 1'b1;

    apply(32'h0010_8133 | 32'h0000_0080, 32'h0, 32'd5, 32'd7);
    apply(32'h0011_01B3, 32'h0, 32'd5, 32'd7);
    chk("add_result", result, 32'd12);
    chk("add_reg_wr", 32'(reg_wr), 32'd1);
    chk("add_result_q", result_q, 32'd12);

    // Async clear mid-cycle, then release between edges.
    #2 clr = 1'b0;
    #1;
    chk("clr_result_q", result_q, 32'h0);
    chk("clr_zero_q", 32'(zero_q), 32'h0);
    chk("clr_less_q", 32'(less_q), 32'h0);
    chk("clr_comb_result", result, 32'd12);
    #1 clr = 1'b1;
    #1;
    chk("release_hold_q", result_q, 32'h0);
    @(posedge clk); #1;
    chk("release_capture_q", result_q, 32'd12);

    apply(32'h4011_01B3, 32'h0, 32'd5, 32'd7);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_less", 32'(less_flag), 32'd1);
    apply(32'h4011_01B3, 32'h0, 32'd9, 32'd9);
    chk("sub_zero", 32'(zero_flag), 32'd1);
    apply(32'h1234_5037, 32'h0, 32'h0, 32'h0);
    chk("lui_result", result, 32'h1234_5000);
    apply(32'h0000_1097, 32'h100, 32'h0, 32'h0);
    chk("auipc_result", result, 32'h0000_1100);
    apply(32'hFE20_EEE3, 32'h0, 32'd1, 32'hFFFF_FFFF);
    chk("bltu_imm", imm, 32'hFFFF_FFFC);
    chk("bltu_branch", 32'(branch), 32'd6);
    chk("bltu_less", 32'(less_flag), 32'd1);
    apply(32'hFE20_CEE3, 32'h0, 32'd1, 32'hFFFF_FFFF);
    chk("blt_less", 32'(less_flag), 32'd0);
    apply(32'h4041_D193, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_result", result, 32'hF800_0000);
    chk("srai_ctrl", 32'(alu_ctrl), 32'd13);
    apply(32'h0080_A183, 32'h0, 32'h0000_1000, 32'h0);
    chk("lw_result", result, 32'h0000_1008);
    chk("lw_mem_op", 32'(mem_op), 32'd2);
    apply(32'h0020_A423, 32'h0, 32'h0000_2000, 32'h55);
    chk("sw_imm", imm, 32'd8);
    chk("sw_mem_wr", 32'(mem_wr), 32'd1);
    apply(32'h0000_007F, 32'h40, 32'd3, 32'd4);
    chk("illegal_reg_wr", 32'(reg_wr), 32'd0);
    chk("illegal_result", result, 32'd7);
    apply(32'h0080_00EF, 32'h200, 32'h0, 32'h0);
    chk("jal_result", result, 32'h204);

    for (int k = 0; k < 400; k++) begin
      ri = $urandom;
      ri[6:0] = opcodes[$urandom_range(0, 12)];
      if (ri[6:0] == 7'h63 && ri[14:13] == 2'b01) ri[14] = 1'b1;
      apply(ri, $urandom, ($urandom_range(0, 3) == 0) ? 32'(ri[19:15]) : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_exec.md
Name: rv32i_decode_exec

Overview:
- Single-cycle decode/execute slice of the RV32I core: control unit, immediate generator, ALU operand muxes and ALU in one block.
- Consumes the fetched instruction, current PC and the two register-file read values.
- Produces the datapath control signals, the 32-bit immediate, the ALU result and flags (combinational), plus one registered copy of result and flags.

Parameters:
XLEN, 32, datapath width (fixed at 32; only RV32I is supported)

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-low
instr  in  32  current instruction
pc  in  32  address of current instruction
rs1  in  32  register-file port A data
rs2  in  32  register-file port B data
alu_a_src  out  1  1 = ALU A takes rs1, 0 = ALU A takes pc
alu_b_src  out  2  00 = rs2, 01 = imm, 10 = constant 4, 11 = unused (ALU B driven 0)
alu_ctrl  out  4  ALU operation code
branch  out  3  branch/jump type
mem_to_reg  out  1  1 = writeback from data memory
mem_op  out  3  memory access size/sign (funct3)
mem_wr  out  1  data memory write enable
reg_wr  out  1  register-file write enable
imm  out  32  sign-extended immediate
result  out  32  combinational ALU result
zero_flag  out  1  result == 0
less_flag  out  1  a < b (signedness per alu_ctrl)
result_q  out  32  registered result
zero_q  out  1  registered zero_flag
less_q  out  1  registered less_flag

Behaviour:
- All outputs except the *_q outputs are purely combinational from instr, pc, rs1 and rs2.
- alu_ctrl encoding {f7[5],f3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1111 pass B.
  - Any other code yields 0.
- Shifts use b[4:0]. SLT/SLTU return 0 or 1.
- less_flag: unsigned a<b when alu_ctrl = 0011, otherwise signed a<b.
- zero_flag: result == 0.
- Decode by opcode:
  - 0110011 R: A=rs1, B=rs2, ctrl {f7[5],f3}, reg_wr.
  - 0010011 I-ALU: A=rs1, B=imm, ctrl {f3==101 ? f7[5] : 0, f3}, reg_wr.
  - 0000011 load: A=rs1, B=imm, ADD, mem_to_reg, reg_wr, mem_op=f3.
  - 0100011 store: A=rs1, B=imm, ADD, mem_wr, mem_op=f3.
  - 1100011 branch: A=rs1, B=rs2, ctrl SUB (f3 = 000/001/100/101) or SLTU (f3 = 110/111).
  - 0110111 LUI: B=imm, ctrl 1111, reg_wr.
  - 0010111 AUIPC: A=pc, B=imm, ADD, reg_wr.
  - 1101111 JAL: A=pc, B=4, ADD, reg_wr, branch 001.
  - 1100111 JALR: same as JAL but branch 010.
- branch codes:
  - 000 none, 001 JAL, 010 JALR.
  - 100 BEQ, 101 BNE, 110 BLT/BLTU, 111 BGE/BGEU.
  - 011 is unused and never driven.
- Unlisted opcode (illegal): reg_wr = mem_wr = mem_to_reg = 0, branch 000, alu_ctrl ADD, A=rs1, B=rs2, imm 0.
- mem_op is f3 for every opcode; it is meaningful only with loads/stores.
- Immediate formats, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and illegal: 0.
- Register stage:
  - result_q/zero_q/less_q load result/zero_flag/less_flag on every rising clk; latency exactly 1 cycle.
  - clr low clears them to 0 immediately, independent of clk. Combinational outputs are unaffected by clr.
  - Release of clr takes effect at the next rising edge.
- All arithmetic is mod 2^32; overflow is ignored.

Test Plan:
- ADD 0x001101B3, rs1=5, rs2=7 -> alu_a_src=1, alu_b_src=00, alu_ctrl=0000, reg_wr=1, result=12, zero=0; result_q=12 one edge later.
- SUB 0x401101B3, rs1=5, rs2=7 -> alu_ctrl=1000, result=0xFFFFFFFE, less_flag=1. Same with rs1=rs2=9 -> result 0, zero_flag=1.
- LUI 0x12345037 -> imm=0x12345000, alu_ctrl=1111, result=0x12345000. AUIPC 0x00001097, pc=0x100 -> result 0x1100.
- BLTU 0xFE20EEE3 (rs1=1, rs2=0xFFFFFFFF) -> imm=0xFFFFFFFC, branch=110, alu_ctrl=0011, less_flag=1, reg_wr=0. Same operands under BLT 0xFE20CEE3 -> less_flag=0.
- SRAI 0x4041D193, rs1=0x80000000 -> alu_ctrl=1101, imm[4:0]=4, result=0xF8000000. LW 0x0080A183 -> mem_to_reg=1, mem_op=010, result=rs1+8. SW 0x0020A423 -> mem_wr=1, imm=8.
- Reset: after result_q is nonzero, drive clr low between clock edges -> result_q/zero_q/less_q = 0 immediately. Hold clr high again -> capture resumes at the next rising edge. Illegal opcode 0x0000007F -> reg_wr=mem_wr=0, branch=000.
